// File: rtl/olo_intf_edge_event_queue.sv
// Edge-event recorder: per-channel edge detect, {seq, mask} entries queued in a register FIFO.
// Latency: edge at clock N shows on Out_Valid after edge N; full queue drops events (counted) unless popped that cycle.

module olo_intf_edge_event_queue_fifo #(
  parameter int Width_g = 8,
  parameter int Depth_g = 16
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [Width_g-1:0]         In_Data,
  input  logic                       In_Valid,
  output logic                       In_Ready,
  output logic [Width_g-1:0]         Out_Data,
  output logic                       Out_Valid,
  input  logic                       Out_Ready,
  output logic [$clog2(Depth_g):0]   Level,
  output logic                       Full,
  output logic                       Empty
);

  localparam int AddrW = $clog2(Depth_g);
  localparam int LvlW  = AddrW + 1;
  localparam logic [LvlW-1:0] DepthLvl = LvlW'(Depth_g);

  logic [Width_g-1:0] mem [Depth_g];
  logic [AddrW-1:0]   wr_ptr;
  logic [AddrW-1:0]   rd_ptr;
  logic [LvlW-1:0]    level_r;
  logic               push;
  logic               pop;

  assign Empty     = (level_r == '0);
  assign Full      = (level_r == DepthLvl);
  assign Level     = level_r;
  assign Out_Valid = ~Empty;
  assign Out_Data  = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign In_Ready = ~Full | (Out_Valid & Out_Ready);
  assign push     = In_Valid & In_Ready;
  assign pop      = Out_Valid & Out_Ready;

  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr] <= In_Data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_r <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AddrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AddrW'(1);
      end
      case ({push, pop})
        2'b10:   level_r <= level_r + LvlW'(1);
        2'b01:   level_r <= level_r - LvlW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

module olo_intf_edge_event_queue #(
  parameter int    Width_g    = 3,
  parameter string EdgeMode_g = "rising",
  parameter int    Depth_g    = 16,
  parameter int    SeqWidth_g = 8
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic [Width_g-1:0]              In_Data,
  output logic [SeqWidth_g+Width_g-1:0]   Out_Data,
  output logic                            Out_Valid,
  input  logic                            Out_Ready,
  output logic [$clog2(Depth_g):0]        Level,
  output logic                            Full,
  output logic                            Empty,
  output logic                            Overflow,
  output logic [15:0]                     DropCnt,
  input  logic                            ClrDrop
);

  typedef struct packed {
    logic [SeqWidth_g-1:0] seq;
    logic [Width_g-1:0]    mask;
  } entry_t;

  logic [Width_g-1:0]    last_r;
  logic                  primed_r;
  logic [SeqWidth_g-1:0] seq_r;
  logic                  overflow_r;
  logic [15:0]           drop_cnt_r;
  logic [Width_g-1:0]    edges;
  logic [Width_g-1:0]    mask;
  logic                  event_vld;
  logic                  fifo_in_rdy;
  logic                  drop;
  entry_t                push_entry;

  if (EdgeMode_g == "falling") begin : gen_falling
    assign edges = ~In_Data & last_r;
  end else if (EdgeMode_g == "both") begin : gen_both
    assign edges = In_Data ^ last_r;
  end else begin : gen_rising
    assign edges = In_Data & ~last_r;
  end

  // Until the first post-reset sample is in last_r, levels already high are not edges.
  assign mask      = primed_r ? edges : '0;
  assign event_vld = |mask;
  assign drop      = event_vld & ~fifo_in_rdy;

  assign push_entry.seq  = seq_r;
  assign push_entry.mask = mask;

  olo_intf_edge_event_queue_fifo #(
    .Width_g (SeqWidth_g + Width_g),
    .Depth_g (Depth_g)
  ) i_fifo (
    .Clk       (Clk),
    .Rst       (Rst),
    .In_Data   (push_entry),
    .In_Valid  (event_vld),
    .In_Ready  (fifo_in_rdy),
    .Out_Data  (Out_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Level     (Level),
    .Full      (Full),
    .Empty     (Empty)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      last_r     <= '0;
      primed_r   <= 1'b0;
      seq_r      <= '0;
      overflow_r <= 1'b0;
      drop_cnt_r <= '0;
    end else begin
      last_r   <= In_Data;
      primed_r <= 1'b1;
      // Dropped events still consume a sequence number so the consumer sees the gap.
      if (event_vld) begin
        seq_r <= seq_r + SeqWidth_g'(1);
      end
      if (drop) begin
        overflow_r <= 1'b1;
        if (ClrDrop) begin
          drop_cnt_r <= 16'd1;
        end else if (drop_cnt_r != 16'hFFFF) begin
          drop_cnt_r <= drop_cnt_r + 16'd1;
        end
      end else if (ClrDrop) begin
        overflow_r <= 1'b0;
        drop_cnt_r <= '0;
      end
    end
  end

  assign Overflow = overflow_r;
  assign DropCnt  = drop_cnt_r;

endmodule

// File: tb/tb_olo_intf_edge_event_queue.sv
// Directed bench: instance a is rising-edge depth 4, instance b is both-edge depth 4.
module tb_olo_intf_edge_event_queue;

  logic        Clk = 1'b0;
  logic        Rst;

  logic [2:0]  a_in;
  logic        a_rdy;
  logic        a_clr;
  logic [10:0] a_dat;
  logic        a_vld;
  logic [2:0]  a_lvl;
  logic        a_full;
  logic        a_empty;
  logic        a_ovf;
  logic [15:0] a_drop;

  logic [2:0]  b_in;
  logic        b_rdy;
  logic        b_clr;
  logic [10:0] b_dat;
  logic        b_vld;
  logic [2:0]  b_lvl;
  logic        b_full;
  logic        b_empty;
  logic        b_ovf;
  logic [15:0] b_drop;

  int total = 0;
  int bad   = 0;

  logic [10:0] exp_q[$];
  logic [7:0]  seq;
  logic [2:0]  msk;

  always #5 Clk = ~Clk;

  olo_intf_edge_event_queue #(
    .Width_g(3), .EdgeMode_g("rising"), .Depth_g(4), .SeqWidth_g(8)
  ) dut_a (
    .Clk(Clk), .Rst(Rst), .In_Data(a_in), .Out_Data(a_dat), .Out_Valid(a_vld),
    .Out_Ready(a_rdy), .Level(a_lvl), .Full(a_full), .Empty(a_empty),
    .Overflow(a_ovf), .DropCnt(a_drop), .ClrDrop(a_clr)
  );

  olo_intf_edge_event_queue #(
    .Width_g(3), .EdgeMode_g("both"), .Depth_g(4), .SeqWidth_g(8)
  ) dut_b (
    .Clk(Clk), .Rst(Rst), .In_Data(b_in), .Out_Data(b_dat), .Out_Valid(b_vld),
    .Out_Ready(b_rdy), .Level(b_lvl), .Full(b_full), .Empty(b_empty),
    .Overflow(b_ovf), .DropCnt(b_drop), .ClrDrop(b_clr)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Rst   = 1'b1;
    a_in  = 3'b111;
    a_rdy = 1'b0;
    a_clr = 1'b0;
    b_in  = 3'b000;
    b_rdy = 1'b1;
    b_clr = 1'b0;
    tick(); tick(); tick();

    chk("rst_vld",   32'(a_vld),   32'd0);
    chk("rst_lvl",   32'(a_lvl),   32'd0);
    chk("rst_empty", 32'(a_empty), 32'd1);
    chk("rst_full",  32'(a_full),  32'd0);
    chk("rst_ovf",   32'(a_ovf),   32'd0);
    chk("rst_drop",  32'(a_drop),  32'd0);

    // Release; a holds 111 (prime suppression), b exercises both-edge mode.
    Rst = 1'b0;
    tick();
    b_in = 3'b010;
    tick();
    chk("b_rise_vld", 32'(b_vld), 32'd1);
    chk("b_rise_dat", 32'(b_dat), 32'h002);
    tick();
    chk("b_rise_pop_lvl", 32'(b_lvl), 32'd0);
    tick();
    b_in = 3'b000;
    tick();
    chk("b_fall_vld", 32'(b_vld), 32'd1);
    chk("b_fall_dat", 32'(b_dat), 32'h00A);
    tick();
    chk("b_fall_pop_lvl",   32'(b_lvl),   32'd0);
    chk("b_fall_pop_empty", 32'(b_empty), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("prime_vld", 32'(a_vld), 32'd0);
    chk("prime_lvl", 32'(a_lvl), 32'd0);

    // Single edge then simultaneous edges.
    a_in = 3'b000;
    tick();
    chk("fall_in_rise_mode", 32'(a_vld), 32'd0);
    a_in = 3'b001;
    tick();
    chk("first_vld", 32'(a_vld), 32'd1);
    chk("first_dat", 32'(a_dat), 32'h001);
    chk("first_lvl", 32'(a_lvl), 32'd1);
    tick();
    a_in = 3'b111;
    tick();
    chk("two_lvl",       32'(a_lvl), 32'd2);
    chk("two_head_hold", 32'(a_dat), 32'h001);
    a_rdy = 1'b1;
    tick();
    chk("second_dat", 32'(a_dat), 32'h00E);
    chk("second_lvl", 32'(a_lvl), 32'd1);
    tick();
    chk("drained_empty", 32'(a_empty), 32'd1);
    chk("drained_vld",   32'(a_vld),   32'd0);
    a_rdy = 1'b0;

    // Overflow: fresh reset, six events into a depth-4 queue.
    Rst  = 1'b1;
    a_in = 3'b000;
    tick();
    Rst = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      a_in = 3'b001; tick();
      a_in = 3'b000; tick();
    end
    chk("ovf_full", 32'(a_full), 32'd1);
    chk("ovf_lvl",  32'(a_lvl),  32'd4);
    chk("ovf_flag", 32'(a_ovf),  32'd1);
    chk("ovf_cnt",  32'(a_drop), 32'd2);
    a_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      seq = 8'(i);
      chk("drain_order", 32'(a_dat), 32'({seq, 3'b001}));
      tick();
    end
    a_rdy = 1'b0;
    chk("drain_empty", 32'(a_empty), 32'd1);
    a_in = 3'b001;
    tick();
    chk("gap_seq6", 32'(a_dat), 32'h031);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("clr_ovf",  32'(a_ovf),  32'd0);
    chk("clr_cnt",  32'(a_drop), 32'd0);

    // Refill to full (seq 7..9), then drop together with ClrDrop: drop wins.
    for (int i = 0; i < 3; i++) begin
      a_in = 3'b000; tick();
      a_in = 3'b001; tick();
    end
    chk("refill_full", 32'(a_full), 32'd1);
    a_in = 3'b000;
    tick();
    a_in  = 3'b001;
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("clr_vs_drop_ovf", 32'(a_ovf),  32'd1);
    chk("clr_vs_drop_cnt", 32'(a_drop), 32'd1);
    chk("clr_vs_drop_lvl", 32'(a_lvl),  32'd4);

    // Full queue, push and pop every cycle; seq 10 was dropped so next is 11.
    exp_q = '{11'h031, 11'h039, 11'h041, 11'h049};
    seq   = 8'd11;
    a_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      msk  = (k % 2 == 0) ? 3'b010 : 3'b001;
      a_in = msk;
      chk("pp_head", 32'(a_dat), 32'(exp_q[0]));
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back({seq, msk});
      seq = seq + 8'd1;
      chk("pp_lvl",  32'(a_lvl),  32'd4);
      chk("pp_drop", 32'(a_drop), 32'd1);
    end
    chk("pp_final_head", 32'(a_dat), 32'(exp_q[0]));

    // Mid-operation reset at level 3.
    tick();
    a_rdy = 1'b0;
    chk("pre_rst_lvl", 32'(a_lvl), 32'd3);
    Rst  = 1'b1;
    a_in = 3'b111;
    tick();
    chk("mid_rst_vld",   32'(a_vld),   32'd0);
    chk("mid_rst_lvl",   32'(a_lvl),   32'd0);
    chk("mid_rst_empty", 32'(a_empty), 32'd1);
    Rst = 1'b0;
    tick(); tick(); tick();
    chk("mid_rst_prime", 32'(a_vld), 32'd0);
    a_in = 3'b110;
    tick();
    chk("mid_rst_fall", 32'(a_vld), 32'd0);
    a_in = 3'b111;
    tick();
    chk("mid_rst_ev_vld", 32'(a_vld), 32'd1);
    chk("mid_rst_seq0",   32'(a_dat), 32'h001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
